// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - shared types and helpers for the register-bank write arbiter.
package dff_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam int unsigned MAX_DEPTH  = 64;
  localparam int unsigned RESET_DATA = 0;

  // Out-of-range addresses decode to all-zero so the write is silently dropped.
  function automatic logic [MAX_DEPTH-1:0] onehot_dec(input int unsigned addr,
                                                      input int unsigned depth);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (i < depth && i == addr) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/dff_bank_wr_arb_rr_pick.sv
// rtl/dff_bank_wr_arb_rr_pick.sv - find-first-set from a start pointer, wrapping at NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [PW:0]       sum;

  always_comb begin
    dbl    = {req, req} >> ptr;
    rot    = dbl[NREQ-1:0];
    valid  = |req;
    winner = '0;
    sum    = '0;
    // Descending scan so the smallest offset from ptr is the last to assign.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum    = {1'b0, ptr} + (PW+1)'(i);
        winner = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/dff_bank_wr_arb.sv
// rtl/dff_bank_wr_arb.sv - one-write-per-two-cycles arbiter driving a shared DFF bank.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module dff_bank_wr_arb
  import dff_bank_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [DEPTH-1:0]      bank_en,
  output logic [WIDTH-1:0]      bank_d,
  output logic                  busy
);

  state_t                 state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          win;
  logic                   win_valid;
  logic [AW-1:0]          win_addr;
  logic [MAX_DEPTH-1:0]   dec;
  logic                   unused_dec;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (win),
    .valid  (win_valid)
  );

  assign win_addr   = req_addr[win*AW +: AW];
  assign dec        = onehot_dec(32'(win_addr), int'(DEPTH));
  assign unused_dec = ^dec;
  assign busy       = (|req) | (state == WRITE);

`ifdef ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (state == ARB && win_valid) begin
      rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      bank_en <= '0;
      bank_d  <= WIDTH'(RESET_DATA);
    end else begin
      case (state)
        IDLE: begin
          if (|req) state <= ARB;
        end
        ARB: begin
          if (win_valid) begin
            gnt     <= NREQ'(1) << win;
            bank_en <= dec[DEPTH-1:0];
            bank_d  <= req_data[win*WIDTH +: WIDTH];
            state   <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE: begin
          gnt     <= '0;
          bank_en <= '0;
          // A granted requester still holding req is re-arbitrated from the advanced pointer.
          state   <= (|req) ? ARB : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_wr_arb.sv
// tb/tb_dff_bank_wr_arb.sv - scoreboard bench for dff_bank_wr_arb.
module tb_dff_bank_wr_arb;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [DEPTH-1:0]      bank_en;
  logic [WIDTH-1:0]      bank_d;
  logic                  busy;

  dff_bank_wr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .bank_en  (bank_en),
    .bank_d   (bank_d),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NREQ-1:0]  g;
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] d;
    int               c;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  bit   auto_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_val);
    total++;
    if (act === req_val) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req_val);
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [DEPTH-1:0] en,
                      input logic [WIDTH-1:0] d, input int c);
    exp_t e;
    e.g = g; e.en = en; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_addr[i*AW +: AW]       = a;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Requesters register gnt and drop req one cycle later when auto_drop is set.
  task automatic step();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = gnt;
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~g;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!$isunknown(gnt) && gnt != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_gnt", 32'(gnt), 32'h0);
      end else begin
        e = q.pop_front();
        chk("gnt", 32'(gnt), 32'(e.g));
        chk("bank_en", 32'(bank_en), 32'(e.en));
        chk("bank_d", 32'(bank_d), 32'(e.d));
        chk("gnt_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  initial begin
    int k;
    rst = 1'b0; req = '0; req_addr = '0; req_data = '0;
    steps(3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_bank_en", 32'(bank_en), 32'h0);
    chk("rst_bank_d", 32'(bank_d), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();

    // Single requester
    auto_drop = 1'b1;
    set_req(2, 2'd2, 8'hA5);
    req = 4'b0100;
    push(4'b0100, 4'b0100, 8'hA5, cyc + 2);
    steps(6);
    chk("single_idle_busy", 32'(busy), 32'h0);

    // Same-address collision
    set_req(0, 2'd1, 8'h11);
    set_req(1, 2'd1, 8'h22);
    req = 4'b0011;
    k = cyc;
    push(4'b0001, 4'b0010, 8'h11, k + 2);
    push(4'b0010, 4'b0010, 8'h22, k + 4);
    steps(8);
    chk("collision_last_d", 32'(bank_d), 32'h22);
    chk("collision_busy", 32'(busy), 32'h0);

    // Withdrawal during ARB
    set_req(1, 2'd3, 8'h77);
    req = 4'b0010;
    steps(1);
    req = 4'b0000;
    steps(4);
    chk("withdraw_busy", 32'(busy), 32'h0);
    chk("withdraw_d_held", 32'(bank_d), 32'h22);

    // Reset in the WRITE cycle
    set_req(3, 2'd3, 8'h5A);
    req = 4'b1000;
    push(4'b1000, 4'b1000, 8'h5A, cyc + 2);
    steps(2);
    chk("midwrite_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    req = 4'b0000;
    steps(1);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_bank_en", 32'(bank_en), 32'h0);
    chk("midrst_bank_d", 32'(bank_d), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    steps(2);

    auto_drop = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    // Round-robin fairness from a freshly reset pointer
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'(8'h30 + i));
    req = 4'b1111;
    k = cyc;
    for (int n = 0; n < 8; n++)
      push(4'(1 << (n % 4)), 4'(1 << (n % 4)), 8'(8'h30 + n % 4), k + 2 + 2 * n);
    steps(16);
    req = 4'b0000;
    steps(4);
`else
    // Fixed priority: requester 3 starves behind requester 1
    set_req(1, 2'd1, 8'h41);
    set_req(3, 2'd3, 8'h43);
    req = 4'b1010;
    k = cyc;
    for (int n = 0; n < 6; n++) push(4'b0010, 4'b0010, 8'h41, k + 2 + 2 * n);
    steps(12);
    req = 4'b0000;
    steps(4);
`endif

    chk("pending_expected", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
